reg_writeback_unit: RTL

//  Register file plus writeback stage of the multicycle MIPS datapath, directly downstream of the controller.

---
 rtl/reg_writeback_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: register file and writeback stage of a multicycle MIPS datapath.
// Latches operand registers A/B from the rs/rt fields of IR on every clock edge.
// Selects the write address and write data from the controller outputs.
// Provides a combinational debug read port.
// Optional build macro REG_BYPASS_EN: when a same-edge write hits rs/rt, A/B capture the
// new write data instead of the stale register contents.
module reg_writeback_unit #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int RA_IDX = 31,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ir,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] mdr,
   input  logic [DATA_W-1:0] pc,
   input  logic              RegDst,
   input  logic              LastReg,
   input  logic              MemtoReg,
   input  logic              PCtoReg,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_IDX);

   logic [DATA_W-1:0] rf_q [NREGS];
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              unused_ir;

   // IR register fields, truncated to the register-file address width.
   assign rs_addr = ir[21 +: ADDR_W];
   assign rt_addr = ir[16 +: ADDR_W];
   assign rd_addr = ir[11 +: ADDR_W];
   assign unused_ir = ^{ir[31:26], ir[10:0]};

   // Write-address and write-data selection; LastReg and PCtoReg take priority.
   always_comb begin
      waddr = RegDst ? rd_addr : rt_addr;
      if (LastReg) waddr = RA_ADDR;
      wdata = MemtoReg ? mdr : alu_out;
      if (PCtoReg) wdata = pc;
      we = RegWrite && (waddr != '0);
   end

   // Next operand values, with optional forwarding of a same-edge write.
   always_comb begin
      a_d = rf_q[rs_addr];
      b_d = rf_q[rt_addr];
`ifdef REG_BYPASS_EN
      if (we && (waddr == rs_addr)) a_d = wdata;
      if (we && (waddr == rt_addr)) b_d = wdata;
`endif
   end

   // Register file storage; writes to $0 are suppressed through we, so rf_q[0] stays zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (we) begin
         rf_q[waddr] <= wdata;
      end
   end

   // Operand registers A and B, reloaded on every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign dbg_data = rf_q[dbg_addr];

endmodule
